// File: rtl/crc_seq_ctrl_if.sv
// crc_seq_ctrl_if
// Groups the host-interface handshake and the CRC datapath control lines of
// the byte-serial CRC sequencing controller.
//   master : host interface / bench side. It drives the write, size, init and
//            reset-chain requests and observes the stall and datapath controls.
//   slave  : the controller itself.
// Signal names follow the CRC host interface naming so that they line up with
// the surrounding AHB CRC block.
interface crc_seq_ctrl_if #(
    parameter int BYTE_CNT_W = 2
);
    logic                  buffer_write_en;
    logic [1:0]            bus_size;
    logic                  crc_init_en;
    logic                  reset_chain;
    logic                  buffer_full;
    logic                  read_wait;
    logic                  reset_pending;
    logic                  load_word;
    logic [BYTE_CNT_W-1:0] byte_sel;
    logic                  crc_calc_en;
    logic                  crc_init_load;
    logic                  busy;

    modport master (
        output buffer_write_en, bus_size, crc_init_en, reset_chain,
        input  buffer_full, read_wait, reset_pending, load_word,
               byte_sel, crc_calc_en, crc_init_load, busy
    );

    modport slave (
        input  buffer_write_en, bus_size, crc_init_en, reset_chain,
        output buffer_full, read_wait, reset_pending, load_word,
               byte_sel, crc_calc_en, crc_init_load, busy
    );
endinterface

// File: rtl/crc_seq_ctrl.sv
// crc_seq_ctrl
// Sequencing controller for the byte-serial CRC engine. It holds one pending
// CRC_DR word and feeds it to the datapath one byte per cycle (LSB lane first)
// according to the captured bus size. It also orders CRC_INIT reloads and
// reset_chain requests against data in flight, and produces the host stall
// flags.
// Ports:
//   HCLK    : clock
//   HRESET  : synchronous active-high reset
//   bus     : crc_seq_ctrl_if.slave
//             inputs  buffer_write_en, bus_size, crc_init_en, reset_chain
//             outputs buffer_full, read_wait, reset_pending, load_word,
//                     byte_sel, crc_calc_en, crc_init_load, busy
// Every output is a flop. Its next value is decoded from the next register
// state, so the outputs match a decode of the current registers and there is
// no path from an input to an output.
module crc_seq_ctrl #(
    parameter int BYTE_CNT_W = 2
) (
    input  logic           HCLK,
    input  logic           HRESET,
    crc_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_INIT = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  buf_vld_q, buf_vld_d;
    logic [1:0]            buf_size_q, buf_size_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [BYTE_CNT_W-1:0] last_cnt_q, last_cnt_d;
    logic                  pend_init_q, pend_init_d;
    logic                  pend_rst_q, pend_rst_d;

    logic                  buffer_full_q, buffer_full_d;
    logic                  read_wait_q, read_wait_d;
    logic                  reset_pending_q, reset_pending_d;
    logic                  load_word_q, load_word_d;
    logic [BYTE_CNT_W-1:0] byte_sel_q, byte_sel_d;
    logic                  crc_calc_en_q, crc_calc_en_d;
    logic                  crc_init_load_q, crc_init_load_d;
    logic                  busy_q, busy_d;

    logic                  wr_acc;

    // Index of the last byte lane for a given bus size (size 11 is a word).
    function automatic logic [BYTE_CNT_W-1:0] last_of(input logic [1:0] size);
        logic [BYTE_CNT_W-1:0] res;
        case (size)
            2'b00:   res = {BYTE_CNT_W{1'b0}};
            2'b01:   res = BYTE_CNT_W'(1);
            default: res = {BYTE_CNT_W{1'b1}};
        endcase
        return res;
    endfunction

    // Next-state sequencing plus decode of the next output values.
    always_comb begin
        state_d     = state_q;
        buf_vld_d   = buf_vld_q;
        buf_size_d  = buf_size_q;
        byte_cnt_d  = byte_cnt_q;
        last_cnt_d  = last_cnt_q;
        pend_init_d = pend_init_q;
        pend_rst_d  = pend_rst_q;

        // buffer_full_q is the registered flag seen by the host this cycle.
        // A write in the same cycle as reset_chain is dropped.
        wr_acc = bus.buffer_write_en & ~buffer_full_q & ~bus.reset_chain;

        case (state_q)
            ST_IDLE: begin
                if (pend_rst_q || pend_init_q) begin
                    state_d = ST_INIT;
                end else if (buf_vld_q) begin
                    buf_vld_d  = 1'b0;
                    byte_cnt_d = {BYTE_CNT_W{1'b0}};
                    last_cnt_d = last_of(buf_size_q);
                    state_d    = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (byte_cnt_q == last_cnt_q) begin
                    if (buf_vld_q) begin
                        // Chain straight into the next word with no bubble.
                        buf_vld_d  = 1'b0;
                        byte_cnt_d = {BYTE_CNT_W{1'b0}};
                        last_cnt_d = last_of(buf_size_q);
                        state_d    = ST_CALC;
                    end else if (pend_init_q) begin
                        state_d = ST_INIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                end
            end
            ST_INIT: begin
                pend_init_d = 1'b0;
                pend_rst_d  = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_acc) begin
            buf_vld_d  = 1'b1;
            buf_size_d = bus.bus_size;
        end else begin
            buf_size_d = buf_size_d;
        end

        // A request that arrives during the INIT cycle stays pending and is
        // served by a further INIT cycle.
        if (bus.crc_init_en) begin
            pend_init_d = 1'b1;
        end else begin
            pend_init_d = pend_init_d;
        end

        // reset_chain has priority. It drops the buffered word and aborts
        // any byte stream or pending load straight into INIT.
        if (bus.reset_chain) begin
            pend_rst_d = 1'b1;
            buf_vld_d  = 1'b0;
            if (state_q != ST_INIT) begin
                state_d = ST_INIT;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            pend_rst_d = pend_rst_d;
        end

        reset_pending_d = pend_init_d | pend_rst_d;
        buffer_full_d   = buf_vld_d | reset_pending_d;
        busy_d          = (state_d != ST_IDLE);
        read_wait_d     = buf_vld_d | busy_d | reset_pending_d;
        crc_calc_en_d   = (state_d == ST_CALC);
        crc_init_load_d = (state_d == ST_INIT);
        byte_sel_d      = crc_calc_en_d ? byte_cnt_d : {BYTE_CNT_W{1'b0}};
        load_word_d     = ((state_d == ST_IDLE) & buf_vld_d & ~reset_pending_d) |
                          ((state_d == ST_CALC) & buf_vld_d & (byte_cnt_d == last_cnt_d));
    end

    // State, counter, flag and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q         <= ST_IDLE;
            buf_vld_q       <= 1'b0;
            buf_size_q      <= 2'b00;
            byte_cnt_q      <= {BYTE_CNT_W{1'b0}};
            last_cnt_q      <= {BYTE_CNT_W{1'b0}};
            pend_init_q     <= 1'b0;
            pend_rst_q      <= 1'b0;
            buffer_full_q   <= 1'b0;
            read_wait_q     <= 1'b0;
            reset_pending_q <= 1'b0;
            load_word_q     <= 1'b0;
            byte_sel_q      <= {BYTE_CNT_W{1'b0}};
            crc_calc_en_q   <= 1'b0;
            crc_init_load_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            buf_vld_q       <= buf_vld_d;
            buf_size_q      <= buf_size_d;
            byte_cnt_q      <= byte_cnt_d;
            last_cnt_q      <= last_cnt_d;
            pend_init_q     <= pend_init_d;
            pend_rst_q      <= pend_rst_d;
            buffer_full_q   <= buffer_full_d;
            read_wait_q     <= read_wait_d;
            reset_pending_q <= reset_pending_d;
            load_word_q     <= load_word_d;
            byte_sel_q      <= byte_sel_d;
            crc_calc_en_q   <= crc_calc_en_d;
            crc_init_load_q <= crc_init_load_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.buffer_full   = buffer_full_q;
    assign bus.read_wait     = read_wait_q;
    assign bus.reset_pending = reset_pending_q;
    assign bus.load_word     = load_word_q;
    assign bus.byte_sel      = byte_sel_q;
    assign bus.crc_calc_en   = crc_calc_en_q;
    assign bus.crc_init_load = crc_init_load_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// tb_crc_seq_ctrl
// Directed, table-driven bench for crc_seq_ctrl.
// Each table row gives the outputs expected during one cycle, together with
// the inputs driven in that same cycle. The expected output vector packs the
// signals as {buffer_full, read_wait, reset_pending, load_word, byte_sel[1:0],
// crc_calc_en, crc_init_load, busy}. A hand-written back-to-back word sequence
// follows the table.
module tb_crc_seq_ctrl;

    logic HCLK;
    logic HRESET;

    crc_seq_ctrl_if #(.BYTE_CNT_W(2)) bus ();

    crc_seq_ctrl #(.BYTE_CNT_W(2)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    typedef struct {
        string      name;
        logic       hr;
        logic       wr;
        logic [1:0] sz;
        logic       ini;
        logic       rc;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic [8:0] outs();
        return {bus.buffer_full, bus.read_wait, bus.reset_pending, bus.load_word,
                bus.byte_sel, bus.crc_calc_en, bus.crc_init_load, bus.busy};
    endfunction

    task automatic add(input string name, input logic hr, input logic wr,
                       input logic [1:0] sz, input logic ini, input logic rc,
                       input logic [8:0] exp);
        vec_t v;
        v.name = name; v.hr = hr; v.wr = wr; v.sz = sz;
        v.ini = ini; v.rc = rc; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic hr, input logic wr, input logic [1:0] sz,
                         input logic ini, input logic rc);
        HRESET              = hr;
        bus.buffer_write_en = wr;
        bus.bus_size        = sz;
        bus.crc_init_en     = ini;
        bus.reset_chain     = rc;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        logic [8:0] cur;
        int budget;
        n_pass  = 0;
        n_total = 0;
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        cyc();
        cyc();

        // Field order: bf rw rp lw bs ce il by
        add("rst_hold",  1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        // 1: single word write
        add("t1_idle",   1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        add("t1_load",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_0_1_00_0_0_0);
        add("t1_b0",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_00_1_0_1);
        add("t1_b1",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_01_1_0_1);
        add("t1_b2",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_10_1_0_1);
        add("t1_b3",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_11_1_0_1);
        // 2: halfword, then byte written when buffer_full drops
        add("t2_idle",   1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        add("t2_load",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_0_1_00_0_0_0);
        add("t2_h0",     1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_00_1_0_1);
        add("t2_h1_ld",  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_0_1_01_1_0_1);
        add("t2_b0",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_00_1_0_1);
        // 3: CRC_INIT written mid-word, ordered after the data
        add("t3_idle",   1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        add("t3_load",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_0_1_00_0_0_0);
        add("t3_b0",     1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 9'b0_1_0_0_00_1_0_1);
        add("t3_b1",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_1_0_01_1_0_1);
        add("t3_b2",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_1_0_10_1_0_1);
        add("t3_b3",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_1_0_11_1_0_1);
        add("t3_init",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_1_0_00_0_1_1);
        // 4: reset_chain at byte_sel=1 with a second word buffered
        add("t4_idle",   1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        add("t4_load",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_0_1_00_0_0_0);
        add("t4_b0",     1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 9'b0_1_0_0_00_1_0_1);
        add("t4_b1_rc",  1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 9'b1_1_0_0_01_1_0_1);
        add("t4_init",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_1_0_00_0_1_1);
        add("t4_idle1",  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        // 5: write and reset_chain in the same cycle
        add("t5_wr_rc",  1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 9'b0_0_0_0_00_0_0_0);
        add("t5_init",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_1_0_00_0_1_1);
        add("t5_idle1",  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        // 6: HRESET during CALC, then a size-11 write processes 4 bytes
        add("t6_idle",   1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        add("t6_load",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_0_1_00_0_0_0);
        add("t6_b0_rst", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_00_1_0_1);
        add("t6_post",   1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        add("t6_load2",  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_0_1_00_0_0_0);
        add("t6_b0",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_00_1_0_1);
        add("t6_b1",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_01_1_0_1);
        add("t6_b2",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_10_1_0_1);
        add("t6_b3",     1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_1_0_0_11_1_0_1);
        // simultaneous CRC_INIT and reset_chain: one INIT serves both
        add("t7_both",   1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 9'b0_0_0_0_00_0_0_0);
        add("t7_init",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b1_1_1_0_00_0_1_1);
        add("t7_idle",   1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);
        add("t7_idle2",  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 9'b0_0_0_0_00_0_0_0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].hr, vecs[i].wr, vecs[i].sz, vecs[i].ini, vecs[i].rc);
            check(vecs[i].name, outs(), vecs[i].exp);
            cyc();
        end

        // Back-to-back words: the second word is written as soon as
        // buffer_full drops, and the bytes run 0..3,0..3 with no gap.
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        budget = 10;
        while (bus.buffer_full && budget > 0) begin
            cyc();
            budget = budget - 1;
        end
        check("b2b_full_drop", {8'd0, bus.buffer_full}, 9'd0);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cur = {7'd0, bus.crc_calc_en, 1'b0} | {7'd0, bus.byte_sel};
            cur = {6'd0, bus.crc_calc_en, bus.byte_sel};
            check($sformatf("b2b_byte%0d", k), cur, {6'd0, 1'b1, 2'(k % 4)});
            cyc();
            drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        end
        check("b2b_done", outs(), 9'b0_0_0_0_00_0_0_0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
